button_conditioner: RTL and testbench

- Upstream stage for the ripple counter. Takes a raw, asynchronous, bouncing push-button and delivers a clean single-cycle press pulse. That pulse is the counter stage0 clock/enable source.
- Also provides a debounced level and a release pulse for any other button consumer on the board.
- Runs entirely in the board clock domain. One instance per button.

---
 rtl/button_pkg.sv | 18 +
 rtl/sync_2ff.sv | 34 +++
 rtl/button_conditioner.sv | 182 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button conditioner.
package button_pkg;

    // Debounce FSM states: two stable states, each with a qualifying wait state.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_e;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat rate at 100 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned REPEAT_DELAY_DEF    = 50000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 10000000;
    localparam int unsigned CNT_W_DEF           = 24;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by the
// synchronous active-low reset. Also used for the other board buttons.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Next values: the raw input shifts through the two stages.
    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    // Synchronizer stages; reset clears both to the released state.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes a raw bouncing button, debounces it
// and produces a clean level plus one-cycle press and release pulses.
// Optional auto-repeat of the press pulse while held: BUTTON_AUTOREPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if ($clog2(DEBOUNCE_CYCLES) > CNT_W) begin : g_bad_cnt_w
        $error("button_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
    end

    // Terminal count: the last wait cycle before a new level is accepted.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync2;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             accept_press;
    logic             rpt_pulse;

    // Only the synchronized copy of the button ever reaches the FSM.
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (sync2)
    );

    // Saturating increment: holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Debounce next-state, counter and pulse decode.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept_press = 1'b0;
        release_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync2) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d      = PRESSED;
                    cnt_d        = '0;
                    accept_press = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync2) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The debounced level is high in both "pressed" states, so it flips on
    // the same edge as the accepting pulse.
    assign level_d = (state_d == PRESSED) || (state_d == WAIT_LOW);
    assign press_d = accept_press | rpt_pulse;

    // FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    // The repeat timer may need more bits than the debounce counter, since
    // the default repeat delay exceeds 2^24 cycles.
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_LOG = $clog2(RPT_MAX);
    localparam int unsigned RPT_W   = (RPT_LOG > CNT_W) ? RPT_LOG : CNT_W;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RPT_W-1:0] rpt_last;
    logic             rpt_first_q, rpt_first_d;

    // Repeat timer: runs only while held in PRESSED; anything else re-arms it
    // so each entry into PRESSED starts a fresh REPEAT_DELAY.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_pulse   = 1'b0;
        rpt_last    = rpt_first_q ? DELAY_LAST : PERIOD_LAST;
        if (state_q == PRESSED && sync2) begin
            if (rpt_cnt_q == rpt_last) begin
                rpt_pulse   = 1'b1;
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end else if (rpt_cnt_q != '1) begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end else begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner. A window-based reference model
// (a button value must be seen on DEBOUNCE_CYCLES+1 consecutive synchronized
// samples to be accepted) is compared against the DUT on every cycle.
module tb_button_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, btn_press, btn_release;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (24),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit       dly[$];          // two-edge synchronizer delay of btn_in
    bit       m_level, m_press, m_release, m_prev_s;
    int       ones_run, zeros_run, since_entry;
    logic [2:0] led_cnt;       // downstream 3-bit counter fed by btn_press

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        bit s;
        bit was_level;
        m_press   = 1'b0;
        m_release = 1'b0;
        if (!reset) begin
            dly.delete();
            dly.push_back(1'b0);
            dly.push_back(1'b0);
            m_level     = 1'b0;
            m_prev_s    = 1'b0;
            ones_run    = 0;
            zeros_run   = 0;
            since_entry = 0;
            return;
        end
        s = dly.pop_front();
        dly.push_back(btn_in);
        was_level = m_level;
        if (s) begin
            ones_run++;
            zeros_run = 0;
        end else begin
            zeros_run++;
            ones_run = 0;
        end
        if (!was_level && ones_run == int'(DB) + 1) begin
            m_level     = 1'b1;
            m_press     = 1'b1;
            since_entry = 0;
        end else if (was_level && zeros_run == int'(DB) + 1) begin
            m_level   = 1'b0;
            m_release = 1'b1;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (was_level && s) begin
            if (!m_prev_s) begin
                since_entry = 0;
            end else begin
                since_entry++;
                if (since_entry >= int'(RD) && (since_entry - int'(RD)) % int'(RP) == 0)
                    m_press = 1'b1;
            end
        end
`endif
        m_prev_s = s;
    endtask

    // One clock: update model at the edge, compare outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("level", btn_level, m_level);
        check("press", btn_press, m_press);
        check("release", btn_release, m_release);
        if (btn_press === 1'b1) led_cnt = led_cnt + 3'd1;
    endtask

    // Run n clocks, counting pulses and noting the first edge of each kind.
    task automatic hold(input int n, output int np, output int nr,
                        output int fp, output int fr);
        np = 0; nr = 0; fp = 0; fr = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (btn_press === 1'b1) begin
                np++;
                if (fp == 0) fp = k;
            end
            if (btn_release === 1'b1) begin
                nr++;
                if (fr == 0) fr = k;
            end
        end
    endtask

    initial begin
        int np, nr, fp, fr;
        int acc;
        int offs[$];
        int rpt_exp[4];

        led_cnt = 3'd0;

        // Reset state.
        reset  = 1'b0;
        btn_in = 1'b0;
        hold(3, np, nr, fp, fr);
        check("rst_level", btn_level, 1'b0);
        check("rst_press", btn_press, 1'b0);
        check("rst_release", btn_release, 1'b0);
        reset = 1'b1;
        hold(4, np, nr, fp, fr);

        // Clean press: single pulse seven edges after the rise.
        btn_in = 1'b1;
        hold(20, np, nr, fp, fr);
        check_int("press_latency", fp, 7);
        check_int("press_count", np, 1);
        check_int("press_release_count", nr, 0);
        check("press_level", btn_level, 1'b1);

        // Clean release.
        btn_in = 1'b0;
        hold(20, np, nr, fp, fr);
        check_int("release_latency", fr, 7);
        check_int("release_count", nr, 1);
        check_int("release_press_count", np, 0);
        check("release_level", btn_level, 1'b0);

        // Bounce rejection: 2-cycle glitches never qualify.
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            btn_in = (i % 2 == 0);
            hold(2, np, nr, fp, fr);
            acc += np + nr;
        end
        btn_in = 1'b0;
        hold(10, np, nr, fp, fr);
        acc += np + nr;
        check_int("bounce_pulses", acc, 0);
        check("bounce_level", btn_level, 1'b0);

        // Reset in WAIT_HIGH with counter at 2, button kept held.
        btn_in = 1'b1;
        hold(5, np, nr, fp, fr);
        check_int("pre_rst_press", np, 0);
        reset = 1'b0;
        hold(1, np, nr, fp, fr);
        check("mid_rst_level", btn_level, 1'b0);
        check("mid_rst_press", btn_press, 1'b0);
        reset = 1'b1;
        hold(12, np, nr, fp, fr);
        check_int("rst_resume_latency", fp, 7);
        check_int("rst_resume_count", np, 1);
        btn_in = 1'b0;
        hold(12, np, nr, fp, fr);
        check_int("rst_resume_release", fr, 7);

`ifndef BUTTON_AUTOREPEAT_EN
        // Long hold without auto-repeat: exactly one press.
        btn_in = 1'b1;
        hold(40, np, nr, fp, fr);
        check_int("long_hold_presses", np, 1);
        btn_in = 1'b0;
        hold(12, np, nr, fp, fr);
`endif

        // Downstream hookup: five presses advance the 3-bit counter to 5.
        led_cnt = 3'd0;
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1;
            hold(10, np, nr, fp, fr);
            btn_in = 1'b0;
            hold(10, np, nr, fp, fr);
        end
        check_int("led_count", int'(led_cnt), 5);

        // Randomized bouncing with occasional resets, checked every cycle.
        for (int i = 0; i < 200; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            hold(int'($urandom_range(1, 12)), np, nr, fp, fr);
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b0;
                hold(1, np, nr, fp, fr);
                reset = 1'b1;
            end
        end
        btn_in = 1'b0;
        hold(15, np, nr, fp, fr);
        check("settle_level", btn_level, 1'b0);

`ifdef BUTTON_AUTOREPEAT_EN
        // Auto-repeat: pulses at acceptance, then +10, +13, +16, +19.
        rpt_exp = '{10, 13, 16, 19};
        btn_in = 1'b1;
        hold(7, np, nr, fp, fr);
        check_int("rpt_accept", fp, 7);
        offs.delete();
        for (int k = 1; k <= 30; k++) begin
            if (k == 18) btn_in = 1'b0;
            step();
            if (btn_press === 1'b1) offs.push_back(k);
        end
        check_int("rpt_count", offs.size(), 4);
        if (offs.size() == 4) begin
            for (int i = 0; i < 4; i++) check_int("rpt_offset", offs[i], rpt_exp[i]);
        end
        check("rpt_level_after", btn_level, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
